// File: rtl/raw_tracker.sv
// Tracks the destination register and result of the instructions in EX, MEM and WB,
// drives the forwarding select/value pairs, and raises a one-cycle load-use stall.
module raw_tracker #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rd_sel,
  input  logic             id_reg_we,
  input  logic             id_is_load,
  input  logic [4:0]       id_rs1_sel,
  input  logic [4:0]       id_rs2_sel,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             flush,
  input  logic [XLEN-1:0]  ex_alu_val,
  input  logic [XLEN-1:0]  mem_load_val,
  output logic [4:0]       EX_raw_sel,
  output logic [XLEN-1:0]  EX_raw_val,
  output logic [4:0]       MEM_raw_sel,
  output logic [XLEN-1:0]  MEM_raw_val,
  output logic [4:0]       WB_raw_sel,
  output logic [XLEN-1:0]  WB_raw_val,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  logic            ex_v_q, ex_v_d, ex_we_q, ex_we_d, ex_ld_q, ex_ld_d;
  logic [4:0]      ex_rd_q, ex_rd_d;
  logic            mem_v_q, mem_v_d, mem_we_q, mem_we_d, mem_ld_q, mem_ld_d;
  logic [4:0]      mem_rd_q, mem_rd_d;
  logic [XLEN-1:0] mem_alu_q, mem_alu_d;
  logic            wb_v_q, wb_v_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_val_q, wb_val_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ex_wr, mem_wr, rs1_hit, rs2_hit, bubble;

  always_comb begin
    ex_wr   = ex_v_q & ex_we_q & (ex_rd_q != 5'd0);
    mem_wr  = mem_v_q & mem_we_q & (mem_rd_q != 5'd0);
    rs1_hit = id_uses_rs1 & (id_rs1_sel == ex_rd_q);
    rs2_hit = id_uses_rs2 & (id_rs2_sel == ex_rd_q);
    // Gated by rst so the combinational outputs read 0 throughout reset.
    stall   = !rst & !flush & id_valid & ex_wr & ex_ld_q & (rs1_hit | rs2_hit);

    // A load in EX still drives its select so older MEM/WB matches get masked.
    EX_raw_sel  = ex_wr ? ex_rd_q : 5'd0;
    EX_raw_val  = (!rst && ex_wr && !ex_ld_q) ? ex_alu_val : '0;
    MEM_raw_sel = mem_wr ? mem_rd_q : 5'd0;
    MEM_raw_val = mem_wr ? (mem_ld_q ? mem_load_val : mem_alu_q) : '0;
    WB_raw_sel  = wb_v_q ? wb_rd_q : 5'd0;
    WB_raw_val  = wb_v_q ? wb_val_q : '0;
    stall_count = cnt_q;

    bubble  = flush | stall | !id_valid;
    ex_v_d  = !bubble;
    ex_rd_d = bubble ? 5'd0 : id_rd_sel;
    ex_we_d = !bubble & id_reg_we;
    ex_ld_d = !bubble & id_is_load;

    mem_v_d   = ex_v_q;
    mem_rd_d  = ex_rd_q;
    mem_we_d  = ex_we_q;
    mem_ld_d  = ex_ld_q;
    mem_alu_d = ex_alu_val;

    wb_v_d   = mem_wr;
    wb_rd_d  = mem_rd_q;
    wb_val_d = MEM_raw_val;

    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v_q    <= 1'b0;
      ex_rd_q   <= 5'd0;
      ex_we_q   <= 1'b0;
      ex_ld_q   <= 1'b0;
      mem_v_q   <= 1'b0;
      mem_rd_q  <= 5'd0;
      mem_we_q  <= 1'b0;
      mem_ld_q  <= 1'b0;
      mem_alu_q <= '0;
      wb_v_q    <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_val_q  <= '0;
      cnt_q     <= '0;
    end else begin
      ex_v_q    <= ex_v_d;
      ex_rd_q   <= ex_rd_d;
      ex_we_q   <= ex_we_d;
      ex_ld_q   <= ex_ld_d;
      mem_v_q   <= mem_v_d;
      mem_rd_q  <= mem_rd_d;
      mem_we_q  <= mem_we_d;
      mem_ld_q  <= mem_ld_d;
      mem_alu_q <= mem_alu_d;
      wb_v_q    <= wb_v_d;
      wb_rd_q   <= wb_rd_d;
      wb_val_q  <= wb_val_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
